// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial adder controller: FSM encoding,
// slice width and the slice-counter width derivation.
package serial_adder_pkg;

    // Controller states; encoding is fixed so other blocks can decode it.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bits consumed per cycle by the fulladder slice.
    localparam int SLICE_W = 32'sd2;

    // Width of the slice counter: clog2(width/SLICE_W), never below 1.
    function automatic int cnt_width(input int width);
        int slices;
        slices = width / SLICE_W;
        if (slices <= 32'sd1) begin
            return 32'sd1;
        end else begin
            return $clog2(slices);
        end
    endfunction

endpackage

// File: rtl/fulladder.sv
// 2-bit adder slice: {carry,sum} = a + b + c. Purely combinational; it is
// driven from registered controller outputs, so no loop is formed.
module fulladder (
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic       c,
    output logic [1:0] sum,
    output logic       carry
);

    logic [2:0] total_s;

    // Add the two 2-bit operands plus the incoming carry.
    always_comb begin
        total_s = {1'b0, a} + {1'b0, b} + {2'b00, c};
        sum     = total_s[1:0];
        carry   = total_s[2];
    end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Serial adder controller: sequences WIDTH-bit operands through an external
// 2-bit fulladder slice, LSB slice first, chaining the carry between cycles
// and assembling the sum and carry-out.
// Optional feature: define SERIAL_ADDER_OVF_EN to add the signed-overflow
// output `ovf`.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic [1:0]       fa_a,
    output logic [1:0]       fa_b,
    output logic             fa_c,
    input  logic [1:0]       fa_sum,
    input  logic             fa_carry,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH / SLICE_W - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t           state_r;
    state_t           state_next_s;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic             carry_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] res_r;
    logic             cout_r;
    logic             last_slice_s;
`ifdef SERIAL_ADDER_OVF_EN
    logic             a_msb_r;
    logic             b_msb_r;
    logic             ovf_r;
`endif

    assign last_slice_s = (cnt_r == LAST_CNT);

    // Next-state decode; start is honoured only in IDLE, DONE lasts one cycle.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_slice_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register plus registered busy/done decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s == ST_RUN);
            done_r  <= (state_next_s == ST_DONE);
        end
    end

    // Operand capture, slice shifting, carry chaining and result assembly.
    // The operand shifters drain to zero and the carry is cleared on the
    // final slice, so the fa_* outputs are 0 outside RUN straight from flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh_r  <= {WIDTH{1'b0}};
            b_sh_r  <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            res_r   <= {WIDTH{1'b0}};
            cout_r  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            a_msb_r <= 1'b0;
            b_msb_r <= 1'b0;
            ovf_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        a_sh_r  <= op_a;
                        b_sh_r  <= op_b;
                        carry_r <= cin;
                        cnt_r   <= {CW{1'b0}};
`ifdef SERIAL_ADDER_OVF_EN
                        a_msb_r <= op_a[WIDTH-1];
                        b_msb_r <= op_b[WIDTH-1];
`endif
                    end else begin
                        carry_r <= carry_r;
                    end
                end
                ST_RUN: begin
                    res_r  <= (res_r >> SLICE_W) | (WIDTH'(fa_sum) << (WIDTH - SLICE_W));
                    a_sh_r <= a_sh_r >> SLICE_W;
                    b_sh_r <= b_sh_r >> SLICE_W;
                    cnt_r  <= cnt_r + CNT_ONE;
                    if (last_slice_s) begin
                        carry_r <= 1'b0;
                        cout_r  <= fa_carry;
`ifdef SERIAL_ADDER_OVF_EN
                        ovf_r   <= (a_msb_r == b_msb_r) && (fa_sum[1] != a_msb_r);
`endif
                    end else begin
                        carry_r <= fa_carry;
                    end
                end
                ST_DONE: begin
                    carry_r <= 1'b0;
                end
                default: begin
                    carry_r <= 1'b0;
                end
            endcase
        end
    end

    assign fa_a   = a_sh_r[1:0];
    assign fa_b   = b_sh_r[1:0];
    assign fa_c   = carry_r;
    assign busy   = busy_r;
    assign done   = done_r;
    assign result = res_r;
    assign cout   = cout_r;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf    = ovf_r;
`endif

endmodule
